// File: rtl/aes_ecb_reg_ctrl.sv
// Register front-end and launch sequencer for the AES-128 ECB core: collects
// key/plaintext words, fires the core, guards completion with a timeout and exposes status.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a START write; KEY/PT writable
// LAUNCH  | aes_start high for this one cycle; timeout counter cleared
// WAIT    | waiting for aes_done; counter runs until timeout
// CAPTURE | ciphertext latched; sets done_flag and returns to IDLE
module aes_ecb_reg_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    aes_start,
    output logic [4*DATA_WIDTH-1:0] aes_key,
    output logic [4*DATA_WIDTH-1:0] aes_pt,
    input  logic                    aes_done,
    input  logic [4*DATA_WIDTH-1:0] aes_ct,
    output logic                    irq
);

    localparam logic [ADDR_WIDTH-1:0] A_PT0    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(9);
    localparam logic [ADDR_WIDTH-1:0] A_CT0    = ADDR_WIDTH'(12);
    localparam logic [CNT_WIDTH-1:0]  TO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t                        state;
    logic [3:0][DATA_WIDTH-1:0]    key_q;
    logic [3:0][DATA_WIDTH-1:0]    pt_q;
    logic [3:0][DATA_WIDTH-1:0]    ct_q;
    logic [CNT_WIDTH-1:0]          cnt;
    logic                          irq_en;
    logic                          done_flag;
    logic                          err_flag;
    logic                          busy;
    logic                          ctrl_wr;
    logic [1:0]                    widx;
    logic [1:0]                    ridx;
    logic [DATA_WIDTH-1:0]         rd_mux;

    assign busy    = (state != S_IDLE);
    assign ctrl_wr = wr_en && (wr_addr == A_CTRL);
    // Word 0 of each 128-bit group is the most significant word.
    assign widx    = 2'd3 - wr_addr[1:0];
    assign aes_key = key_q;
    assign aes_pt  = pt_q;
    assign irq     = done_flag && irq_en;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= S_IDLE;
            key_q     <= '0;
            pt_q      <= '0;
            ct_q      <= '0;
            cnt       <= '0;
            irq_en    <= 1'b0;
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
            aes_start <= 1'b0;
        end else begin
            aes_start <= 1'b0;

            if (ctrl_wr) begin
                irq_en <= wr_data[2];
                if (wr_data[1]) begin
                    done_flag <= 1'b0;
                    err_flag  <= 1'b0;
                end
            end

            if (wr_en && !busy) begin
                if (wr_addr < A_PT0)
                    key_q[widx] <= wr_data;
                else if (wr_addr < A_CTRL)
                    pt_q[widx] <= wr_data;
            end

            // Flag sets from the sequencer take priority over a same-cycle clear.
            case (state)
                S_IDLE: begin
                    if (ctrl_wr && wr_data[0]) begin
                        state     <= S_LAUNCH;
                        aes_start <= 1'b1;
                        done_flag <= 1'b0;
                        err_flag  <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                    cnt   <= '0;
                end
                S_WAIT: begin
                    if (aes_done) begin
                        ct_q  <= aes_ct;
                        state <= S_CAPTURE;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt == TO_LAST)) begin
                        err_flag <= 1'b1;
                        state    <= S_IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    done_flag <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        ridx   = 2'd3 - rd_addr[1:0];
        if (rd_addr < A_PT0)
            rd_mux = key_q[ridx];
        else if (rd_addr < A_CTRL)
            rd_mux = pt_q[ridx];
        else if (rd_addr == A_CTRL)
            rd_mux[2] = irq_en;
        else if (rd_addr == A_STATUS)
            rd_mux[2:0] = {err_flag, done_flag, busy};
        else if (rd_addr >= A_CT0)
            rd_mux = ct_q[ridx];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_aes_ecb_reg_ctrl.sv
// Scoreboard bench for aes_ecb_reg_ctrl: register-level reference model with a
// latency-configurable stub AES core and a read-response monitor.
module tb_aes_ecb_reg_ctrl;

    localparam int TO = 16;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         rd_en;
    logic [3:0]   rd_addr;
    logic [31:0]  rd_data;
    logic         rd_valid;
    logic         aes_start;
    logic [127:0] aes_key;
    logic [127:0] aes_pt;
    logic         aes_done;
    logic [127:0] aes_ct;
    logic         irq;

    aes_ecb_reg_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .aes_start(aes_start), .aes_key(aes_key), .aes_pt(aes_pt),
        .aes_done(aes_done), .aes_ct(aes_ct), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Stub core: done arrives `stub_lat` cycles after it samples aes_start.
    logic         stub_en;
    logic         force_done;
    logic [127:0] stub_ct;
    int           stub_lat;
    int           stub_cnt;
    always @(posedge ACLK) begin
        if (ARESET)                  stub_cnt <= 0;
        else if (aes_start && stub_en) stub_cnt <= stub_lat;
        else if (stub_cnt > 0)       stub_cnt <= stub_cnt - 1;
    end
    assign aes_done = (stub_cnt == 1) || force_done;
    assign aes_ct   = stub_ct;

    int start_pulses = 0;
    always @(negedge ACLK) if (aes_start === 1'b1) start_pulses++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        int          addr;
    } exp_t;
    exp_t sb[$];

    always @(negedge ACLK) begin
        exp_t e;
        if (rd_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rd_valid with no read pending, rd_data=%h", rd_data);
            end else begin
                e = sb.pop_front();
                if (rd_data !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL rd_addr%0d: got %h at cycle %0d, want %h at cycle %0d",
                             e.addr, rd_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model of the software-visible register state.
    logic [31:0] m_key [4];
    logic [31:0] m_pt  [4];
    logic [31:0] m_ct  [4];
    bit m_irq_en, m_done, m_err, m_busy;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_key[i] = '0; m_pt[i] = '0; m_ct[i] = '0;
        end
        m_irq_en = 0; m_done = 0; m_err = 0; m_busy = 0;
    endtask

    function automatic logic [31:0] model_read(int a);
        logic [31:0] v;
        v = '0;
        if (a < 4)        v = m_key[a];
        else if (a < 8)   v = m_pt[a-4];
        else if (a == 8)  v = {29'b0, m_irq_en, 2'b00};
        else if (a == 9)  v = {29'b0, m_err, m_done, m_busy};
        else if (a >= 12) v = m_ct[a-12];
        return v;
    endfunction

    task automatic model_write(int a, logic [31:0] d);
        if (a < 4) begin
            if (!m_busy) m_key[a] = d;
        end else if (a < 8) begin
            if (!m_busy) m_pt[a-4] = d;
        end else if (a == 8) begin
            m_irq_en = d[2];
            if (d[1]) begin m_done = 0; m_err = 0; end
            if (d[0] && !m_busy) begin m_busy = 1; m_done = 0; m_err = 0; end
        end
    endtask

    task automatic model_complete(logic [127:0] ct);
        m_busy = 0;
        m_done = 1;
        for (int i = 0; i < 4; i++) m_ct[i] = ct[127-32*i -: 32];
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(string name, logic [127:0] got, logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic do_write(int a, logic [31:0] d);
        wr_en = 1'b1; wr_addr = a[3:0]; wr_data = d;
        tick();
        wr_en = 1'b0;
        model_write(a, d);
    endtask

    task automatic do_read(int a);
        rd_en = 1'b1; rd_addr = a[3:0];
        sb.push_back('{data: model_read(a), cyc: cyc + 1, addr: a});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_wr_rd(int a, logic [31:0] d);
        wr_en = 1'b1; wr_addr = a[3:0]; wr_data = d;
        rd_en = 1'b1; rd_addr = a[3:0];
        sb.push_back('{data: model_read(a), cyc: cyc + 1, addr: a});
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        model_write(a, d);
    endtask

    task automatic read_ct();
        for (int w = 12; w < 16; w++) do_read(w);
    endtask

    // Launch one operation; completion is expected exactly lat+2 cycles after START.
    task automatic run_op(int lat, logic [127:0] ct, bit inject);
        int s0;
        s0 = start_pulses;
        stub_lat = lat; stub_ct = ct; stub_en = 1'b1;
        do_write(8, {29'b0, m_irq_en, 2'b01});
        if (inject) begin
            do_write(0, 32'hFFFF_FFFF);
            do_write(8, 32'h1);
            repeat (lat - 2) tick();
        end else begin
            do_read(9);
            repeat (lat - 1) tick();
        end
        do_read(9);
        check("irq_before_capture", irq, 0);
        do_read(9);
        model_complete(ct);
        check("irq_after_capture", irq, m_irq_en & m_done);
        check("start_once", start_pulses, s0 + 1);
        do_read(9);
        read_ct();
    endtask

    initial begin
        logic [127:0] fips_key, fips_pt, fips_ct, ct_r;
        int s0;
        fips_key = 128'h000102030405060708090a0b0c0d0e0f;
        fips_pt  = 128'h00112233445566778899aabbccddeeff;
        fips_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

        ARESET = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
        stub_en = 0; force_done = 0; stub_ct = '0; stub_lat = 10;
        model_reset();
        repeat (3) tick();
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_aes_start", aes_start, 0);
        check("reset_irq", irq, 0);
        check("reset_aes_key", aes_key, 0);
        ARESET = 1'b0;
        tick();
        do_read(9);

        // FIPS-197 vector through a 10-cycle stub
        for (int w = 0; w < 4; w++) do_write(w, fips_key[127-32*w -: 32]);
        for (int w = 0; w < 4; w++) do_write(4 + w, fips_pt[127-32*w -: 32]);
        check("aes_key_drive", aes_key, fips_key);
        check("aes_pt_drive", aes_pt, fips_pt);
        do_read(0);
        do_read(7);
        run_op(10, fips_ct, 0);

        // Writes while busy are dropped
        run_op(10, {$urandom, $urandom, $urandom, $urandom}, 1);
        do_read(0);
        do_read(8);
        check("key_after_busy_write", aes_key, fips_key);

        // Interrupt enable and clear
        do_write(8, 32'h4);
        do_read(8);
        run_op($urandom_range(2, 14), {$urandom, $urandom, $urandom, $urandom}, 0);
        do_write(8, 32'h6);
        check("irq_after_clear", irq, 0);
        do_read(9);
        do_read(8);

        // aes_done outside WAIT is ignored
        stub_ct = {$urandom, $urandom, $urandom, $urandom};
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        read_ct();
        do_read(9);

        // Timeout with a core that never answers
        stub_en = 1'b0;
        stub_ct = {$urandom, $urandom, $urandom, $urandom};
        s0 = start_pulses;
        do_write(8, 32'h1);
        do_read(9);
        repeat (TO - 1) tick();
        do_read(9);
        m_busy = 0; m_err = 1;
        do_read(9);
        read_ct();
        check("timeout_start_once", start_pulses, s0 + 1);
        run_op(5, {$urandom, $urandom, $urandom, $urandom}, 0);

        // Read path: unmapped words, RO words, back-to-back, read/write collision
        do_write(10, $urandom);
        do_write(11, $urandom);
        do_write(9, 32'h7);
        do_write(13, $urandom);
        do_read(10);
        do_read(11);
        do_read(9);
        do_read(9);
        do_read(13);
        do_wr_rd(1, $urandom);
        do_read(1);
        do_wr_rd(8, 32'h4);
        do_read(8);

        // Randomized register traffic and operations
        for (int it = 0; it < 5; it++) begin
            for (int k = 0; k < 8; k++) begin
                int a;
                a = $urandom_range(0, 14);
                if (a >= 8) a = a + 1;
                do_write(a, $urandom);
            end
            do_write(8, {29'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0});
            for (int k = 0; k < 6; k++) do_read($urandom_range(0, 15));
            ct_r = {$urandom, $urandom, $urandom, $urandom};
            run_op($urandom_range(2, 14), ct_r, 0);
            check("aes_key_rand", aes_key, {m_key[0], m_key[1], m_key[2], m_key[3]});
            check("aes_pt_rand", aes_pt, {m_pt[0], m_pt[1], m_pt[2], m_pt[3]});
        end

        // Reset in the middle of WAIT, then a stray done
        do_write(8, 32'h4);
        stub_en = 1'b0;
        do_write(8, 32'h5);
        repeat (4) tick();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        model_reset();
        s0 = start_pulses;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        repeat (3) tick();
        check("rst_no_start", start_pulses, s0);
        check("rst_irq", irq, 0);
        do_read(9);
        read_ct();
        do_read(0);

        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rd_missing: %0d reads never returned, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_ecb_reg_ctrl.md
Name: aes_ecb_reg_ctrl

Overview:
Control and sequencing stage between the AXI4-Lite slave register-write/read path of the AES ECB encrypt IP and the AES-128 encryption core. It collects four key words and four plaintext words, launches the core with a one-cycle start pulse, and waits for completion with a timeout guard. It captures the ciphertext into read-back registers and exposes busy/done/error status to software.

Parameters:
- DATA_WIDTH, 32, register word width. Fixed at 32; any other value is unsupported.
- ADDR_WIDTH, 4, word-index width of the register map (16 words).
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for aes_done. 0 disables the timeout.
- CNT_WIDTH, 16, width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2^CNT_WIDTH.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- wr_en  in  1  one-cycle register write strobe from the AXI4-Lite slave.
- wr_addr  in  ADDR_WIDTH  word index of the write.
- wr_data  in  32  write data.
- rd_en  in  1  register read strobe.
- rd_addr  in  ADDR_WIDTH  word index of the read.
- rd_data  out  32  read data, registered.
- rd_valid  out  1  high one cycle after rd_en.
- aes_start  out  1  one-cycle launch pulse to the AES core.
- aes_key  out  128  key to the AES core.
- aes_pt  out  128  plaintext to the AES core.
- aes_done  in  1  one-cycle completion pulse from the AES core.
- aes_ct  in  128  ciphertext from the AES core, valid when aes_done=1.
- irq  out  1  level interrupt: done_flag AND irq_en.

Behaviour:
- Register map (word index):
  - 0-3: KEY words, word 0 = aes_key[127:96] … word 3 = aes_key[31:0].
  - 4-7: PT words, same ordering applied to aes_pt.
  - 8: CTRL. bit0 START (write-1 launches, reads 0); bit1 DONE_CLR (W1C of done_flag and err_flag, reads 0); bit2 irq_en (R/W).
  - 9: STATUS (RO). bit0 busy, bit1 done_flag, bit2 err_flag.
  - 12-15: CT words (RO), word 12 = ct[127:96].
  - 10, 11: unmapped. Read 0; writes ignored.
- aes_key and aes_pt are driven continuously from the KEY/PT registers.
- Reset: all registers cleared to 0. Outputs rd_data=0, rd_valid=0, aes_start=0, irq=0. FSM goes to IDLE and the timeout counter clears. An in-flight operation is abandoned; an aes_done arriving after reset is ignored.
- FSM states: IDLE, LAUNCH, WAIT, CAPTURE.
  - IDLE: a write to CTRL with bit0=1 moves to LAUNCH, clears done_flag/err_flag, and sets busy.
  - LAUNCH: aes_start=1 for exactly one cycle; next state is WAIT; counter := 0.
  - WAIT: on aes_done=1, move to CAPTURE. Otherwise the counter increments. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without aes_done, return to IDLE with err_flag=1, busy=0, and CT unchanged.
  - CAPTURE: entered with aes_ct latched into CT on the aes_done cycle. Set done_flag=1, busy=0, return to IDLE. Total latency from the START write to busy=0 is core latency + 2 cycles.
- busy=1 in LAUNCH, WAIT and CAPTURE. While busy:
  - Writes to KEY/PT/START are ignored.
  - irq_en and DONE_CLR writes are accepted.
- aes_done outside WAIT is ignored and CT is not updated.
- A START and DONE_CLR written in the same word: START wins, and flags are cleared anyway.
- Simultaneous wr_en and rd_en to the same register: the read returns the pre-write value.
- Reads: rd_data/rd_valid are registered, with 1-cycle latency. Back-to-back reads on consecutive cycles are supported. rd_data holds its value when rd_en=0. Reading STATUS on the capture cycle returns the pre-capture value.
- Timeout counter saturates and never wraps.

Test Plan:
- Reset mid-operation:
  - Stimulus: assert ARESET for 1 cycle during WAIT, then pulse aes_done.
  - Response: STATUS reads 0x0, CT reads 0, no aes_start pulse, irq=0.
- FIPS-197 vector with a stub core of 10-cycle latency:
  - Stimulus: KEY = 00010203 04050607 08090a0b 0c0d0e0f; PT = 00112233 44556677 8899aabb ccddeeff; write CTRL=0x1.
  - Response: exactly one aes_start pulse; STATUS=0x1 during the run, then 0x2 at START+12 cycles; CT words 12-15 = 69c4e0d8 6a7b0430 d8cdb780 70b4c55a.
- Writes while busy:
  - Stimulus: while busy, write KEY0=0xFFFFFFFF and CTRL=0x1.
  - Response: KEY0 unchanged and no second aes_start.
- Interrupt and clear:
  - Stimulus: write CTRL=0x4 (irq_en), run a vector, then write CTRL=0x6.
  - Response: irq rises the cycle after capture; after the CTRL=0x6 write, irq=0 and STATUS=0x0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16 with a stub that never asserts done; write START.
  - Response: after the timeout, STATUS=0x4, CT unchanged, FSM back in IDLE; a new START works.
- Read path:
  - Stimulus: read addresses 10 and 11; read STATUS on consecutive cycles.
  - Response: addresses 10/11 return 0; each rd_valid pulses 1 cycle after its rd_en.
